// File: rtl/hit_serializer.sv
// Buffers live groups of per-lane hit candidates in a small FIFO and emits the
// surviving lanes one per cycle over a valid/ready handshake, throttling upstream via halt.
module hit_serializer #(
    parameter int SIGFIG     = 24,
    parameter int RADIX      = 10,
    parameter int AXIS       = 3,
    parameter int COLORS     = 3,
    parameter int SAMPS      = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int SKID       = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] hit_R18S       [AXIS][SAMPS],
    input  logic        [SIGFIG-1:0] color_R18U     [COLORS],
    input  logic        [SAMPS-1:0]  hit_valid_R18H,
    output logic                     halt_RnnnnL,
    output logic signed [SIGFIG-1:0] hit_R19S       [AXIS],
    output logic        [SIGFIG-1:0] color_R19U     [COLORS],
    output logic                     hit_valid_R19H,
    input  logic                     ready_R19H,
    output logic                     overflow_R19H
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int LW = (SAMPS > 1) ? $clog2(SAMPS) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] SKID_C  = CW'(SKID);

    // Position words are fixed point, so the fraction width must fit inside them.
    if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < SKID + 1 || RADIX > SIGFIG) begin : g_bad_params
        $error("hit_serializer: illegal parameter combination");
    end

    function automatic logic [LW-1:0] lowest_lane(input logic [SAMPS-1:0] m);
        lowest_lane = '0;
        for (int i = SAMPS - 1; i >= 0; i--) begin
            if (m[i]) lowest_lane = LW'(i);
        end
    endfunction

    logic signed [SIGFIG-1:0] fifo_hit   [FIFO_DEPTH][AXIS][SAMPS];
    logic        [SIGFIG-1:0] fifo_color [FIFO_DEPTH][COLORS];
    logic        [SAMPS-1:0]  fifo_mask  [FIFO_DEPTH];

    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [SAMPS-1:0] wmask;

    logic             live, have, out_load, take, pop, push;
    logic [SAMPS-1:0] eff_mask, rest_mask;
    logic [LW-1:0]    lane;

    always_comb begin
        live      = |hit_valid_R18H;
        have      = (count != '0);
        out_load  = !hit_valid_R19H || ready_R19H;
        take      = out_load && have;
        // A zero working mask means the head entry has not been started yet.
        eff_mask  = (wmask != '0) ? wmask : fifo_mask[rd_ptr];
        lane      = lowest_lane(eff_mask);
        rest_mask = eff_mask & ~(SAMPS'(1) << lane);
        pop       = take && (rest_mask == '0);
        push      = live && ((count < DEPTH_C) || pop);
    end

    assign halt_RnnnnL = (DEPTH_C - count) > SKID_C;

    // R18 -> FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            for (int a = 0; a < AXIS; a++) begin
                for (int s = 0; s < SAMPS; s++) begin
                    fifo_hit[wr_ptr][a][s] <= hit_R18S[a][s];
                end
            end
            for (int c = 0; c < COLORS; c++) begin
                fifo_color[wr_ptr][c] <= color_R18U[c];
            end
            fifo_mask[wr_ptr] <= hit_valid_R18H;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            wmask         <= '0;
            overflow_R19H <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (take) wmask <= rest_mask;
            if (live && !push) overflow_R19H <= 1'b1;
        end
    end

    // FIFO head -> R19 output register
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_valid_R19H <= 1'b0;
            for (int a = 0; a < AXIS; a++)   hit_R19S[a]   <= '0;
            for (int c = 0; c < COLORS; c++) color_R19U[c] <= '0;
        end else if (out_load) begin
            hit_valid_R19H <= take;
            if (take) begin
                for (int a = 0; a < AXIS; a++)   hit_R19S[a]   <= fifo_hit[rd_ptr][a][lane];
                for (int c = 0; c < COLORS; c++) color_R19U[c] <= fifo_color[rd_ptr][c];
            end
        end
    end

endmodule

// File: tb/tb_hit_serializer.sv
// Directed bench for hit_serializer: single group, back-to-back, empty group,
// backpressure with halt, overflow, and reset while queued.
module tb_hit_serializer;

    logic                clk = 1'b0;
    logic                rst;
    logic signed [23:0]  hit_R18S [3][4];
    logic        [23:0]  color_R18U [3];
    logic        [3:0]   hit_valid_R18H;
    logic                halt_RnnnnL;
    logic signed [23:0]  hit_R19S [3];
    logic        [23:0]  color_R19U [3];
    logic                hit_valid_R19H;
    logic                ready_R19H;
    logic                overflow_R19H;

    int compared = 0;
    int mismatched = 0;

    hit_serializer dut (
        .clk(clk), .rst(rst),
        .hit_R18S(hit_R18S), .color_R18U(color_R18U), .hit_valid_R18H(hit_valid_R18H),
        .halt_RnnnnL(halt_RnnnnL),
        .hit_R19S(hit_R19S), .color_R19U(color_R19U), .hit_valid_R19H(hit_valid_R19H),
        .ready_R19H(ready_R19H), .overflow_R19H(overflow_R19H)
    );

    always #5 clk = ~clk;

    function automatic logic signed [23:0] exp_hit(input int tag, input int a, input int s);
        int v;
        v = tag * 256 + a * 16 + s;
        if (a == 1) v = -v;
        return 24'(v);
    endfunction

    function automatic logic [23:0] exp_col(input int tag, input int c);
        return 24'(32'h100000 + tag * 4 + c);
    endfunction

    task automatic drive(input logic [3:0] mask, input int tag);
        for (int a = 0; a < 3; a++)
            for (int s = 0; s < 4; s++) hit_R18S[a][s] = exp_hit(tag, a, s);
        for (int c = 0; c < 3; c++) color_R18U[c] = exp_col(tag, c);
        hit_valid_R18H = mask;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ready_R19H = 1'b0;
        drive(4'b0000, 0);
        step();
        step();
        compared++;
        if (hit_valid_R19H !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %0b want 0", hit_valid_R19H); end
        compared++;
        if (halt_RnnnnL !== 1'b1) begin mismatched++; $display("FAIL reset_halt: got %0b want 1", halt_RnnnnL); end
        compared++;
        if (overflow_R19H !== 1'b0) begin mismatched++; $display("FAIL reset_overflow: got %0b want 0", overflow_R19H); end
        for (int a = 0; a < 3; a++) begin
            compared++;
            if (hit_R19S[a] !== 24'sd0) begin mismatched++; $display("FAIL reset_hit[%0d]: got %0h want 0", a, hit_R19S[a]); end
            compared++;
            if (color_R19U[a] !== 24'd0) begin mismatched++; $display("FAIL reset_color[%0d]: got %0h want 0", a, color_R19U[a]); end
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [3:0] msk [5] = '{4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic       ev  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        int         el  [5] = '{0, 0, 1, 3, 0};
        ready_R19H = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(msk[i], 1);
            step();
            compared++;
            if (hit_valid_R19H !== ev[i]) begin mismatched++; $display("FAIL single_valid cyc%0d: got %0b want %0b", i, hit_valid_R19H, ev[i]); end
            if (ev[i]) begin
                for (int a = 0; a < 3; a++) begin
                    compared++;
                    if (hit_R19S[a] !== exp_hit(1, a, el[i])) begin mismatched++; $display("FAIL single_hit cyc%0d ax%0d: got %0h want %0h", i, a, hit_R19S[a], exp_hit(1, a, el[i])); end
                    compared++;
                    if (color_R19U[a] !== exp_col(1, a)) begin mismatched++; $display("FAIL single_color cyc%0d ch%0d: got %0h want %0h", i, a, color_R19U[a], exp_col(1, a)); end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] msk [7] = '{4'b1111, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        int         tg  [7] = '{2, 3, 0, 0, 0, 0, 0};
        logic       ev  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int         et  [7] = '{0, 2, 2, 2, 2, 3, 0};
        int         el  [7] = '{0, 0, 1, 2, 3, 0, 0};
        ready_R19H = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(msk[i], tg[i]);
            step();
            compared++;
            if (hit_valid_R19H !== ev[i]) begin mismatched++; $display("FAIL b2b_valid cyc%0d: got %0b want %0b", i, hit_valid_R19H, ev[i]); end
            if (ev[i]) begin
                for (int a = 0; a < 3; a++) begin
                    compared++;
                    if (hit_R19S[a] !== exp_hit(et[i], a, el[i])) begin mismatched++; $display("FAIL b2b_hit cyc%0d ax%0d: got %0h want %0h", i, a, hit_R19S[a], exp_hit(et[i], a, el[i])); end
                    compared++;
                    if (color_R19U[a] !== exp_col(et[i], a)) begin mismatched++; $display("FAIL b2b_color cyc%0d ch%0d: got %0h want %0h", i, a, color_R19U[a], exp_col(et[i], a)); end
                end
            end
        end
    endtask

    task automatic test_empty_group();
        logic [3:0] msk [6] = '{4'b0011, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        int         tg  [6] = '{4, 5, 6, 0, 0, 0};
        logic       ev  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        int         et  [6] = '{0, 4, 4, 6, 0, 0};
        int         el  [6] = '{0, 0, 1, 2, 0, 0};
        ready_R19H = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(msk[i], tg[i]);
            step();
            compared++;
            if (hit_valid_R19H !== ev[i]) begin mismatched++; $display("FAIL empty_valid cyc%0d: got %0b want %0b", i, hit_valid_R19H, ev[i]); end
            if (ev[i]) begin
                for (int a = 0; a < 3; a++) begin
                    compared++;
                    if (hit_R19S[a] !== exp_hit(et[i], a, el[i])) begin mismatched++; $display("FAIL empty_hit cyc%0d ax%0d: got %0h want %0h", i, a, hit_R19S[a], exp_hit(et[i], a, el[i])); end
                    compared++;
                    if (color_R19U[a] !== exp_col(et[i], a)) begin mismatched++; $display("FAIL empty_color cyc%0d ch%0d: got %0h want %0h", i, a, color_R19U[a], exp_col(et[i], a)); end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int k, s, et, el, cnt;
        logic ev, eh;
        for (int i = 0; i < 24; i++) begin
            ready_R19H = (i >= 10);
            if (i < 7) drive(4'b0011, 10 + i);
            else       drive(4'b0000, 99);
            step();
            k = i + 1;
            et = 10; el = 0;
            if (k == 1) ev = 1'b0;
            else if (k <= 10) ev = 1'b1;
            else begin
                s  = k - 10;
                ev = (s < 14);
                et = 10 + s / 2;
                el = s % 2;
            end
            compared++;
            if (hit_valid_R19H !== ev) begin mismatched++; $display("FAIL bp_valid cyc%0d: got %0b want %0b", k, hit_valid_R19H, ev); end
            if (ev) begin
                for (int a = 0; a < 3; a++) begin
                    compared++;
                    if (hit_R19S[a] !== exp_hit(et, a, el)) begin mismatched++; $display("FAIL bp_hit cyc%0d ax%0d: got %0h want %0h", k, a, hit_R19S[a], exp_hit(et, a, el)); end
                end
                compared++;
                if (color_R19U[0] !== exp_col(et, 0)) begin mismatched++; $display("FAIL bp_color cyc%0d: got %0h want %0h", k, color_R19U[0], exp_col(et, 0)); end
            end
            if (k <= 10) begin
                cnt = (k < 7) ? k : 7;
                eh  = (cnt < 5);
                compared++;
                if (halt_RnnnnL !== eh) begin mismatched++; $display("FAIL bp_halt cyc%0d: got %0b want %0b", k, halt_RnnnnL, eh); end
            end
        end
        compared++;
        if (overflow_R19H !== 1'b0) begin mismatched++; $display("FAIL bp_overflow: got %0b want 0", overflow_R19H); end
        compared++;
        if (halt_RnnnnL !== 1'b1) begin mismatched++; $display("FAIL bp_halt_after_drain: got %0b want 1", halt_RnnnnL); end
    endtask

    task automatic test_overflow();
        int n;
        logic signed [23:0] last_x, last_y;
        logic eo;
        ready_R19H = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(4'b0011, 20 + i);
            step();
            eo = (i == 8);
            compared++;
            if (overflow_R19H !== eo) begin mismatched++; $display("FAIL ovf_flag group%0d: got %0b want %0b", i, overflow_R19H, eo); end
        end
        drive(4'b0000, 99);
        ready_R19H = 1'b1;
        n = 0;
        last_x = '0;
        last_y = '0;
        for (int i = 0; i < 20; i++) begin
            if (hit_valid_R19H === 1'b1) begin
                n++;
                last_x = hit_R19S[0];
                last_y = hit_R19S[1];
            end
            step();
        end
        compared++;
        if (n != 16) begin mismatched++; $display("FAIL ovf_sample_count: got %0d want 16", n); end
        compared++;
        if (last_x !== exp_hit(27, 0, 1) || last_y !== exp_hit(27, 1, 1)) begin
            mismatched++; $display("FAIL ovf_last_sample: got %0h/%0h want %0h/%0h", last_x, last_y, exp_hit(27, 0, 1), exp_hit(27, 1, 1));
        end
        compared++;
        if (overflow_R19H !== 1'b1) begin mismatched++; $display("FAIL ovf_sticky: got %0b want 1", overflow_R19H); end
    endtask

    task automatic test_reset_mid_drain();
        ready_R19H = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(4'b1111, 40 + i);
            step();
        end
        drive(4'b0000, 99);
        step();
        compared++;
        if (hit_valid_R19H !== 1'b1) begin mismatched++; $display("FAIL rmd_pre_valid: got %0b want 1", hit_valid_R19H); end
        rst = 1'b1;
        ready_R19H = 1'b1;
        step();
        compared++;
        if (hit_valid_R19H !== 1'b0) begin mismatched++; $display("FAIL rmd_valid: got %0b want 0", hit_valid_R19H); end
        compared++;
        if (halt_RnnnnL !== 1'b1) begin mismatched++; $display("FAIL rmd_halt: got %0b want 1", halt_RnnnnL); end
        compared++;
        if (overflow_R19H !== 1'b0) begin mismatched++; $display("FAIL rmd_overflow: got %0b want 0", overflow_R19H); end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            compared++;
            if (hit_valid_R19H !== 1'b0) begin mismatched++; $display("FAIL rmd_stale cyc%0d: got %0b want 0", i, hit_valid_R19H); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_empty_group();
        test_backpressure();
        test_overflow();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
